// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate byte cache that sits
// between the CPU datapath and a 32-bit-word data memory.
//
// Geometry: 8 blocks x 4 bytes. Address = {tag[7:5], index[4:2], offset[1:0]}.
//
// Ports
//   CLK            clock; all state changes on the rising edge
//   RESET          synchronous, active-high
//   READ, WRITE    CPU load/store request (level, held while BUSYWAIT=1)
//   ADDRESS        CPU byte address
//   WRITEDATA      store byte
//   READDATA       load byte, combinational from the data array
//   BUSYWAIT       CPU stall, combinational
//   MEM_READ       block read strobe to memory
//   MEM_WRITE      block write strobe to memory
//   MEM_ADDRESS    block address {tag,index}
//   MEM_WRITEDATA  block being written back, byte0 in [7:0]
//   MEM_READDATA   block returned by memory, byte0 in [7:0]
//   MEM_BUSYWAIT   memory busy; low in the completion cycle
//
// state     | meaning
// IDLE      | serve hits; on a miss pick WRITEBACK (dirty victim) or FETCH
// WRITEBACK | write the dirty victim block to memory
// FETCH     | read the requested block from memory and install it

module data_cache (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_t;

    state_t      state_q, state_d;

    // Data and tag arrays are deliberately left unreset; valid gates them.
    logic [31:0] data_q [8];
    logic [2:0]  tag_q  [8];
    logic [7:0]  valid_q;
    logic [7:0]  dirty_q;

    logic [2:0]  req_tag;
    logic [2:0]  idx;
    logic [1:0]  off;
    logic        req;
    logic        hit;

    assign req_tag = ADDRESS[7:5];
    assign idx     = ADDRESS[4:2];
    assign off     = ADDRESS[1:0];
    assign req     = READ | WRITE;
    assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);

    assign READDATA = data_q[idx][{off, 3'b000} +: 8];

    always_comb begin
        state_d       = state_q;
        BUSYWAIT      = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = {req_tag, idx};
        MEM_WRITEDATA = data_q[idx];
        case (state_q)
            IDLE: begin
                BUSYWAIT = req && !hit;
                if (req && !hit) begin
                    state_d = dirty_q[idx] ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                BUSYWAIT    = 1'b1;
                MEM_WRITE   = 1'b1;
                // Victim goes back to its own address, not the requested one.
                MEM_ADDRESS = {tag_q[idx], idx};
                if (!MEM_BUSYWAIT) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                BUSYWAIT = 1'b1;
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH && !MEM_BUSYWAIT) begin
                data_q[idx]  <= MEM_READDATA;
                tag_q[idx]   <= req_tag;
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (state_q == IDLE && WRITE && hit) begin
                // A store that missed completes here too, once the refill hits.
                data_q[idx][{off, 3'b000} +: 8] <= WRITEDATA;
                dirty_q[idx]                    <= 1'b1;
            end
        end
    end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache between the CPU's ALU/register-file datapath and the 32-bit-word data memory. It services 8-bit loads and stores from the CPU. It drives the `busywait` stall that holds the PC and gates register-file writeback. Load data returned on `READDATA` is the value written into the register file on `lw`.

## Interface

Geometry is fixed, with no parameters:
- 8 blocks × 4 bytes.
- Address split: tag = `ADDRESS[7:5]`, index = `ADDRESS[4:2]`, offset = `ADDRESS[1:0]`.

Ports:
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RESET` input 1: synchronous, active-high.
- `READ` input 1: CPU load request, level, held until `BUSYWAIT`=0.
- `WRITE` input 1: CPU store request, level, held until `BUSYWAIT`=0.
- `ADDRESS` input 8: CPU byte address.
- `WRITEDATA` input 8: store data.
- `READDATA` output 8: load data, combinational from the cache array.
- `BUSYWAIT` output 1: CPU stall, combinational.
- `MEM_READ` output 1: memory block-read request.
- `MEM_WRITE` output 1: memory block-write request.
- `MEM_ADDRESS` output 6: block address {tag,index}.
- `MEM_WRITEDATA` output 32: block write data; byte0 in [7:0].
- `MEM_READDATA` input 32: block read data; byte0 in [7:0].
- `MEM_BUSYWAIT` input 1: memory busy.

## Operation

Storage per block:
- 32-bit data
- 3-bit tag
- valid bit
- dirty bit

Hit condition: hit = valid[index] && tag[index]==`ADDRESS[7:5]`.

FSM states: IDLE, WRITEBACK, FETCH.

**IDLE**
- `BUSYWAIT` = (`READ`|`WRITE`) && !hit.
- Read hit: `READDATA` = selected byte, with no stall.
- Write hit: byte written at the next edge and dirty set to 1.
- Miss with dirty[index]=1: next state is WRITEBACK.
- Miss with dirty[index]=0: next state is FETCH.
- `READ` and `WRITE` both high: `WRITE` takes priority.

**WRITEBACK**
- Outputs: `MEM_WRITE`=1, `MEM_ADDRESS`={stored tag,index}, `MEM_WRITEDATA`=block data, `BUSYWAIT`=1.
- Leaves at the edge where `MEM_BUSYWAIT`=0, going to FETCH.

**FETCH**
- Outputs: `MEM_READ`=1, `MEM_ADDRESS`={`ADDRESS[7:5]`,index}, `BUSYWAIT`=1.
- At the edge where `MEM_BUSYWAIT`=0:
  - load `MEM_READDATA` into the block
  - tag ← `ADDRESS[7:5]`
  - valid ← 1, dirty ← 0
  - go to IDLE

**Completing the original request**
- In IDLE, the original request now hits.
- `BUSYWAIT` falls in that cycle.
- A store is then performed at the following edge, setting dirty.

**Memory contract**
- Memory raises `MEM_BUSYWAIT` combinationally in the same cycle a request is raised.
- It holds `MEM_BUSYWAIT` high while busy.
- It drops `MEM_BUSYWAIT` for the completion cycle, with `MEM_READDATA` valid in that cycle.

`MEM_READ` and `MEM_WRITE` are never high together. Both are 0 in IDLE.

## Timing

Reset (at the edge with `RESET`=1):
- state → IDLE
- all valid and dirty bits → 0
- `MEM_READ`=`MEM_WRITE`=0

Data and tag arrays are not reset. After reset, `BUSYWAIT`=0 while `READ`=`WRITE`=0.

Reset mid-operation (`RESET` in WRITEBACK or FETCH):
- The operation is abandoned.
- Memory strobes drop from the next cycle.
- No block is updated.

Latencies:
- Hit: 0 stall cycles. Load data is valid in the request cycle; a store commits at the end of that cycle.
- Clean miss: stall = L+1 cycles, where L is memory cycles until completion. This is FETCH plus one IDLE re-check.
- Dirty miss: stall = 2L+1 cycles.

Request changes while stalled:
- `ADDRESS`/`WRITEDATA` changing while `BUSYWAIT`=1 is illegal CPU behaviour.
- The cache uses the live `ADDRESS` and need not detect such changes.

Registered outputs: FSM state, arrays.

Combinational outputs: `BUSYWAIT`, `READDATA`, all `MEM_*` outputs.

## Test plan

1. **Reset, then cold read miss.** Apply reset. `READ` `ADDRESS`=0x05 with memory block 0x01 = 0xDDCCBBAA and L=5.
   - Response: `MEM_READ`=1 with `MEM_ADDRESS`=0x01 for 5 cycles.
   - Then `BUSYWAIT` falls and `READDATA`=0xBB.
   - `MEM_WRITE` never asserts.
2. **Read hit.** Follow 1 with `READ` 0x07.
   - Response: `BUSYWAIT` stays 0, `READDATA`=0xDD, no memory strobe.
3. **Write hit.** `WRITE` 0x04 data 0x5A, then `READ` 0x04.
   - Response: no stall, `READDATA`=0x5A, dirty[1]=1.
4. **Dirty eviction.** `READ` 0x24 (same index 1, tag 1).
   - Response: `MEM_WRITE` with `MEM_ADDRESS`=0x01 and `MEM_WRITEDATA`=0xDDCCBB5A for L cycles.
   - Then `MEM_READ` with `MEM_ADDRESS`=0x09 for L cycles.
   - Then hit; total stall 2L+1.
5. **Write miss (allocate).** `WRITE` 0xE3 data 0x77 to a clean invalid index.
   - Response: fetch of block 0x38 (L cycles).
   - Then byte 3 = 0x77, dirty=1.
   - Subsequent `READ` 0xE3 returns 0x77.
6. **Reset mid-FETCH.** Assert `RESET` in the 2nd FETCH cycle.
   - Response: `MEM_READ` drops the next cycle, state IDLE, and the block remains invalid.
   - A re-issued `READ` misses again.
